// File: rtl/snn_soc_pkg.sv
// Shared SoC sizing constants and the CIM macro model state type.
package snn_soc_pkg;
  localparam int NUM_INPUTS  = 64;
  localparam int NUM_OUTPUTS = 10;
  localparam int ADC_BITS    = 8;
  localparam int VAL_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CIM,
    ST_ADC,
    ST_SCAN
  } cim_model_state_e;
endpackage

// File: rtl/cim_col_value.sv
// Combinational column value generator: differential column pair values from
// the snapshotted popcount, saturated to the ADC range.
module cim_col_value
  import snn_soc_pkg::*;
#(
  parameter int P_NUM_OUTPUTS = NUM_OUTPUTS,
  parameter int P_ADC_BITS    = ADC_BITS,
  parameter int CH_W          = $clog2(2 * P_NUM_OUTPUTS)
) (
  input  logic [VAL_W-1:0]      pop,
  input  logic [CH_W-1:0]       channel,
  output logic [P_ADC_BITS-1:0] value
);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'((1 << P_ADC_BITS) - 1);
  localparam logic [VAL_W-1:0] NO_V  = VAL_W'(P_NUM_OUTPUTS);

  function automatic logic [P_ADC_BITS-1:0] sat(input logic [VAL_W-1:0] v);
    return (v > MAX_V) ? MAX_V[P_ADC_BITS-1:0] : v[P_ADC_BITS-1:0];
  endfunction

  logic [VAL_W-1:0] ch_w;
  logic [VAL_W-1:0] raw;

  always_comb begin
    ch_w = VAL_W'(channel);
    if (ch_w < NO_V) raw = (pop << 1) + ch_w;
    else             raw = (pop >> 1) + (ch_w - NO_V);
    value = sat(raw);
  end
endmodule

// File: rtl/cim_macro_scan_model.sv
// Behavioural CIM macro + ADC scan model. Optional beat dither LFSR is enabled
// by defining CIM_MODEL_DITHER_EN.
module cim_macro_scan_model
  import snn_soc_pkg::*;
#(
  parameter int  P_NUM_INPUTS   = NUM_INPUTS,
  parameter int  P_NUM_OUTPUTS  = NUM_OUTPUTS,
  parameter int  P_ADC_BITS     = ADC_BITS,
  localparam int P_ADC_CHANNELS = 2 * P_NUM_OUTPUTS,
  localparam int CH_W           = $clog2(P_ADC_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_NUM_INPUTS-1:0] wl_spike,
  input  logic                    dac_valid,
  input  logic                    cim_start,
  input  logic [7:0]              cim_lat,
  output logic                    cim_done,
  input  logic                    adc_start,
  input  logic                    adc_mode,
  input  logic [7:0]              adc_lat,
  input  logic [CH_W-1:0]         bl_sel,
  output logic                    bl_valid,
  output logic [CH_W-1:0]         bl_ch,
  output logic [P_ADC_BITS-1:0]   bl_data,
  output logic                    adc_done,
  output logic                    busy,
  output logic [2:0]              err_flags,
  input  logic                    err_clr
);
  localparam logic [CH_W:0]   NCH     = (CH_W + 1)'(P_ADC_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(P_ADC_CHANNELS - 1);

  cim_model_state_e        state_q, state_d;
  logic [P_NUM_INPUTS-1:0] wl_q;
  logic [VAL_W-1:0]        pop_q, pop_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CH_W-1:0]         sel_q, sel_d;
  logic                    beat_q, beat_d;
  logic                    seen_q, seen_d;
  logic [2:0]              err_q, err_d;
  logic [2:0]              err_set;
  logic [CH_W-1:0]         out_ch;
  logic                    out_valid;
  logic [P_ADC_BITS-1:0]   col_val;
  logic [P_ADC_BITS-1:0]   beat_val;
  logic                    sel_bad;

  cim_col_value #(
    .P_NUM_OUTPUTS(P_NUM_OUTPUTS),
    .P_ADC_BITS   (P_ADC_BITS),
    .CH_W         (CH_W)
  ) u_col (
    .pop    (pop_q),
    .channel(out_ch),
    .value  (col_val)
  );

`ifdef CIM_MODEL_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lfsr_q <= 16'hACE1;
    else if (out_valid) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Adding one after saturation equals saturating the raw value plus one.
  assign beat_val = (lfsr_q[0] && (col_val != {P_ADC_BITS{1'b1}})) ? col_val + 1'b1 : col_val;
`else
  assign beat_val = col_val;
`endif

  assign sel_bad   = (state_q == ST_ADC) && ({1'b0, sel_q} >= NCH);
  assign bl_valid  = out_valid;
  assign bl_ch     = out_valid ? out_ch : '0;
  assign bl_data   = (out_valid && !sel_bad) ? beat_val : '0;
  assign busy      = (state_q != ST_IDLE);
  assign err_flags = err_q;

  always_comb begin
    state_d   = state_q;
    pop_d     = pop_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    sel_d     = sel_q;
    beat_d    = beat_q;
    seen_d    = seen_q;
    err_set   = 3'b000;
    cim_done  = 1'b0;
    adc_done  = 1'b0;
    out_valid = 1'b0;
    out_ch    = '0;

    if ((state_q != ST_IDLE) && (cim_start || adc_start)) err_set[0] = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cim_start) begin
          pop_d   = VAL_W'($countones(dac_valid ? wl_spike : wl_q));
          cnt_d   = (cim_lat == 8'd0) ? 8'd1 : cim_lat;
          state_d = ST_CIM;
        end else if (adc_start) begin
          if (!seen_q) begin
            err_set[1] = 1'b1;
            pop_d      = '0;
          end
          cnt_d = (adc_lat == 8'd0) ? 8'd1 : adc_lat;
          if (adc_mode) begin
            beat_d  = 1'b0;
            ch_d    = '0;
            state_d = ST_SCAN;
          end else begin
            sel_d = bl_sel;
            if ({1'b0, bl_sel} >= NCH) err_set[2] = 1'b1;
            state_d = ST_ADC;
          end
        end
      end
      ST_CIM: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          cim_done = 1'b1;
          seen_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ADC: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          out_valid = 1'b1;
          adc_done  = 1'b1;
          out_ch    = sel_q;
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Latency countdown phase, then one beat per cycle from channel 0.
        if (!beat_q) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            out_valid = 1'b1;
            beat_d    = 1'b1;
            ch_d      = CH_W'(1);
          end
        end else begin
          out_valid = 1'b1;
          out_ch    = ch_q;
          ch_d      = ch_q + 1'b1;
          if (ch_q == LAST_CH) begin
            adc_done = 1'b1;
            beat_d   = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wl_q    <= '0;
      pop_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      sel_q   <= '0;
      beat_q  <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      if (dac_valid) wl_q <= wl_spike;
      pop_q   <= pop_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_cim_macro_scan_model.sv
// Directed + randomized bench for cim_macro_scan_model with a popcount-based
// reference model; an extra 6-bit ADC instance checks saturation.
module tb_cim_macro_scan_model;
  localparam int CH  = 20;
  localparam int NO  = 10;
  localparam int CHW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] wl_spike;
  logic        dac_valid, cim_start, adc_start, adc_mode, err_clr;
  logic [7:0]  cim_lat, adc_lat;
  logic [CHW-1:0] bl_sel;
  logic        cim_done, bl_valid, adc_done, busy;
  logic [CHW-1:0] bl_ch;
  logic [7:0]  bl_data;
  logic [2:0]  err_flags;
  logic        cim_done6, bl_valid6, adc_done6, busy6;
  logic [CHW-1:0] bl_ch6;
  logic [5:0]  bl_data6;
  logic [2:0]  err_flags6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cim_macro_scan_model dut (
    .clk(clk), .rst_n(rst_n), .wl_spike(wl_spike), .dac_valid(dac_valid),
    .cim_start(cim_start), .cim_lat(cim_lat), .cim_done(cim_done),
    .adc_start(adc_start), .adc_mode(adc_mode), .adc_lat(adc_lat), .bl_sel(bl_sel),
    .bl_valid(bl_valid), .bl_ch(bl_ch), .bl_data(bl_data), .adc_done(adc_done),
    .busy(busy), .err_flags(err_flags), .err_clr(err_clr)
  );

  cim_macro_scan_model #(.P_ADC_BITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .wl_spike(wl_spike), .dac_valid(dac_valid),
    .cim_start(cim_start), .cim_lat(cim_lat), .cim_done(cim_done6),
    .adc_start(adc_start), .adc_mode(adc_mode), .adc_lat(adc_lat), .bl_sel(bl_sel),
    .bl_valid(bl_valid6), .bl_ch(bl_ch6), .bl_data(bl_data6), .adc_done(adc_done6),
    .busy(busy6), .err_flags(err_flags6), .err_clr(err_clr)
  );

  function automatic int colval(input int pop, input int ch, input int bits);
    int v;
    int mx;
    v  = (ch < NO) ? 2 * pop + ch : pop / 2 + (ch - NO);
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_cim(input logic [63:0] wl, input bit dv, input int lat);
    wl_spike  = wl;
    dac_valid = dv;
    cim_lat   = 8'(lat);
    cim_start = 1'b1;
    step();
    cim_start = 1'b0;
    dac_valid = 1'b0;
  endtask

  // Called n0 cycles after the accept cycle; expects cim_done at cycle leff.
  task automatic wait_cim(input int leff, input int n0);
    int n;
    n = n0;
    while (cim_done !== 1'b1 && n < 40) begin
      check("busy_during_cim", busy, 1);
      step();
      n++;
    end
    check("cim_latency", n, leff);
    check("busy_at_cim_done", busy, 1);
    step();
    check("cim_done_width", cim_done, 0);
    check("busy_after_cim", busy, 0);
  endtask

  task automatic do_adc(input bit mode, input int sel, input int lat, input int pop);
    int n;
    int nb;
    int ch;
    int leff;
    adc_start = 1'b1;
    adc_mode  = mode;
    bl_sel    = CHW'(sel);
    adc_lat   = 8'(lat);
    step();
    adc_start = 1'b0;
    leff = (lat == 0) ? 1 : lat;
    n = 1;
    while (bl_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("adc_latency", n, leff);
    nb = mode ? CH : 1;
    for (int b = 0; b < nb; b++) begin
      ch = mode ? b : sel;
      check("bl_valid", bl_valid, 1);
      check("bl_ch", bl_ch, ch);
      check("bl_data", bl_data, (ch >= CH) ? 0 : colval(pop, ch, 8));
      check("bl_data_6bit", bl_data6, (ch >= CH) ? 0 : colval(pop, ch, 6));
      check("adc_done", adc_done, (b == nb - 1) ? 1 : 0);
      step();
    end
    check("bl_valid_after", bl_valid, 0);
    check("bl_data_idle", bl_data, 0);
    check("bl_ch_idle", bl_ch, 0);
    check("busy_after_adc", busy, 0);
  endtask

  initial begin
    logic [63:0] wl;
    int pop;
    int beats;
    rst_n = 1'b0; wl_spike = '0; dac_valid = 0; cim_start = 0; adc_start = 0;
    adc_mode = 0; err_clr = 0; cim_lat = 0; adc_lat = 0; bl_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_bl_valid", bl_valid, 0);
    check("rst_bl_data", bl_data, 0);
    check("rst_err", err_flags, 0);
    check("rst_cim_done", cim_done, 0);
    rst_n = 1'b1;
    step();

    // All-ones bit-plane latched in the accept cycle, latency 3.
    start_cim({64{1'b1}}, 1'b1, 3);
    wait_cim(3, 1);
    check("err_clean", err_flags, 0);
    do_adc(1'b1, 0, 2, 64);

    // Request while computing is ignored and logged.
    start_cim(64'h0F, 1'b1, 5);
    adc_start = 1'b1; adc_mode = 1'b1; adc_lat = 8'd1;
    step();
    adc_start = 1'b0;
    check("overlap_err", err_flags, 3'b001);
    wait_cim(5, 2);
    beats = 0;
    repeat (4) begin
      if (bl_valid) beats++;
      step();
    end
    check("overlap_ignored_beats", beats, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr", err_flags, 3'b000);

    // Set and clear in the same cycle: set wins.
    start_cim(64'h3, 1'b1, 4);
    cim_start = 1'b1; err_clr = 1'b1;
    step();
    cim_start = 1'b0; err_clr = 1'b0;
    check("set_beats_clr", err_flags, 3'b001);
    wait_cim(4, 2);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Randomized compute/convert rounds using the latched bit-plane.
    for (int it = 0; it < 6; it++) begin
      wl = {$urandom, $urandom};
      wl_spike = wl; dac_valid = 1'b1;
      step();
      pop = $countones(wl);
      start_cim({$urandom, $urandom}, 1'b0, $urandom_range(0, 4));
      wait_cim((cim_lat == 0) ? 1 : int'(cim_lat), 1);
      do_adc(1'($urandom_range(0, 1)), $urandom_range(0, CH - 1), $urandom_range(0, 3), pop);
    end
    check("err_after_random", err_flags, 0);

    // Asynchronous reset in the middle of a scan.
    adc_start = 1'b1; adc_mode = 1'b1; adc_lat = 8'd1;
    step();
    adc_start = 1'b0;
    check("scan_first_beat", bl_valid, 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_bl_valid", bl_valid, 0);
    check("rst_mid_bl_data", bl_data, 0);
    check("rst_mid_bl_ch", bl_ch, 0);
    check("rst_mid_adc_done", adc_done, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beats = 0;
    repeat (25) begin
      step();
      if (bl_valid) beats++;
    end
    check("no_beats_after_rst", beats, 0);

    // Conversion without prior compute: sequence error, pop treated as 0.
    do_adc(1'b0, 5, 1, 0);
    check("seq_err", err_flags, 3'b010);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Out-of-range single channel.
    wl = {$urandom, $urandom};
    start_cim(wl, 1'b1, 2);
    wait_cim(2, 1);
    do_adc(1'b0, 25, 2, $countones(wl));
    check("bad_sel_err", err_flags, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cim_macro_scan_model.md
CIM_MACRO_SCAN_MODEL -- requirements
Module: cim_macro_scan_model

Interface
REQ-001 SHALL have parameter P_NUM_INPUTS, default snn_soc_pkg::NUM_INPUTS (64); WL bitmap width.
REQ-002 SHALL have parameter P_NUM_OUTPUTS, default snn_soc_pkg::NUM_OUTPUTS (10); differential column pairs.
REQ-003 SHALL have parameter P_ADC_BITS, default snn_soc_pkg::ADC_BITS (8); ADC result width.
REQ-004 SHALL derive localparam P_ADC_CHANNELS = 2*P_NUM_OUTPUTS and CH_W = $clog2(P_ADC_CHANNELS).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-006 SHALL have these ports:
- wl_spike  in  P_NUM_INPUTS  WL bit-plane.
- dac_valid  in  1  one-cycle latch strobe.
- cim_start  in  1  compute request.
- cim_lat  in  8  compute latency in cycles.
- cim_done  out  1  one-cycle completion pulse.
- adc_start  in  1  conversion request.
- adc_mode  in  1  0 = single channel, 1 = scan all channels.
- adc_lat  in  8  conversion latency in cycles.
- bl_sel  in  CH_W  channel for single mode.
- bl_valid  out  1  result beat valid.
- bl_ch  out  CH_W  channel of the current beat.
- bl_data  out  P_ADC_BITS  result of the current beat.
- adc_done  out  1  one-cycle end-of-conversion pulse.
- busy  out  1  state is not IDLE.
- err_flags  out  3  sticky errors: [0] overlap, [1] sequence, [2] bad bl_sel.
- err_clr  in  1  clears err_flags.

Function
REQ-007 SHALL latch wl_spike into wl_latched on any cycle where dac_valid=1, including while busy.
REQ-008 SHALL use an FSM with states ST_IDLE, ST_CIM, ST_ADC, ST_SCAN; busy=1 in every state except ST_IDLE.
REQ-009 SHALL accept cim_start only in ST_IDLE.
- On acceptance, snapshot pop = popcount(source) and enter ST_CIM.
- source = wl_spike if dac_valid is high in the same cycle, else wl_latched.
REQ-010 SHALL treat a latency value L of 0 as 1. cim_done pulses L cycles after the accept cycle, and the FSM returns to ST_IDLE in that same cycle.
REQ-011 SHALL accept adc_start only in ST_IDLE; if cim_start and adc_start are both high, cim_start wins.
REQ-012 SHALL give the accepted adc_start priority over err_flags[1] logging; the sequence check in REQ-018 is evaluated on the same accept.
REQ-013 SHALL compute column values with saturation at 2^P_ADC_BITS-1, using at least 16-bit intermediates:
- positive column j < P_NUM_OUTPUTS: 2*pop + j
- negative column j >= P_NUM_OUTPUTS: (pop>>1) + (j - P_NUM_OUTPUTS)
REQ-014 SHALL, in single mode (adc_mode=0):
- capture bl_sel at accept and enter ST_ADC;
- after L cycles, assert bl_valid, adc_done and bl_ch = captured sel for one cycle, with bl_data = value(sel);
- return to ST_IDLE.
REQ-015 SHALL, in scan mode (adc_mode=1):
- wait L cycles, then emit channels 0..P_ADC_CHANNELS-1 on consecutive cycles with bl_valid=1;
- assert adc_done with the final beat;
- return to ST_IDLE on the cycle after the final beat.
REQ-016 SHALL hold bl_data and bl_ch at 0 whenever bl_valid=0.
REQ-017 SHALL set err_flags[0] when cim_start or adc_start arrives outside ST_IDLE; the request is ignored.
REQ-018 SHALL set err_flags[1] when adc_start is accepted and no cim_done has occurred since reset. The conversion still proceeds, with pop=0.
REQ-019 SHALL, on a single-mode accept with bl_sel >= P_ADC_CHANNELS, set err_flags[2] and return bl_data=0.
REQ-020 SHALL clear err_flags on err_clr. If a set condition occurs in the same cycle, the set wins.

Reset
REQ-021 SHALL, on rst_n low at any time (including mid-conversion):
- enter ST_IDLE immediately;
- clear wl_latched, pop, counters and err_flags;
- drive cim_done, adc_done, bl_valid, busy, bl_ch and bl_data to 0;
- clear the "cim_done seen" flag.

Configuration
REQ-022 SHALL, when CIM_MODEL_DITHER_EN is defined, include a 16-bit LFSR (seed 16'hACE1, advanced each emitted beat). Its LSB adds +1 to each beat's value before saturation.
REQ-023 SHALL, when CIM_MODEL_DITHER_EN is undefined, contain no LFSR and produce values exactly per REQ-013.

Structure
REQ-024 SHALL keep NUM_INPUTS, NUM_OUTPUTS, ADC_BITS and the state enum type cim_model_state_e in snn_soc_pkg.
REQ-025 SHALL place saturating column-value generation in sub-module cim_col_value (combinational; inputs pop and channel, output value).

Verification
REQ-026 Bench SHALL cover, with P_NUM_INPUTS=64, P_NUM_OUTPUTS=10, P_ADC_BITS=8, dither off:
- dac_valid with wl_spike all-ones, cim_start with cim_lat=3 -> cim_done exactly 3 cycles after the accept; busy high for those 3 cycles.
- Scan with adc_lat=2 -> 20 beats: ch0=128, ch9=137, ch10=32, ch19=41; adc_done on the ch19 beat.
- P_ADC_BITS=6, pop=64 -> ch0 saturates to 63.
- adc_start during ST_CIM -> ignored, err_flags=3'b001; err_clr -> 3'b000.
- Single mode with bl_sel=25 -> bl_data=0, err_flags[2]=1; rst_n pulsed mid-scan -> all outputs 0 in the next cycle, no further beats.
